ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_reader_pkg.sv | 16 +
 rtl/ram_stream_reader_sync_fifo.sv | 55 +++++
 rtl/ram_stream_reader.sv | 144 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg
//   Shared constants for the RAM burst reader: FSM state encodings and the
//   fixed depth of the output FIFO.
package ram_stream_reader_pkg;

  // Output FIFO depth. Must stay a power of two because sync_fifo pointers
  // wrap by overflow.
  localparam int FIFO_DEPTH = 4;

  // Reader FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/ram_stream_reader_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a combinational head read (first-word fall-through).
//   Push and pop may happen together at any occupancy, including full, because
//   the pop frees the slot the push lands in.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           drop all contents (pointers and count back to 0)
//   push, wdata     write one entry
//   pop             consume the head entry
//   rdata           head entry (all zero after reset)
//   count, empty    occupancy 0..DEPTH
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 33,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Burst reader for a synchronous RAM read port (registered read, 1-cycle
//   latency). A command (start address, length-1) is accepted in IDLE; the
//   reader then issues sequential addresses (wrapping mod 2**addr_bits) at up
//   to one per clock and streams the words out through a 4-deep FIFO that
//   absorbs consumer backpressure.
//   Optional feature macro: RAM_STREAM_READER_ABORT_EN adds an 'abort' input
//   that cancels the active burst and flushes all buffered/in-flight data.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_addr, cmd_len             first address, word count minus one
//   ram_addr, ram_dout            RAM read port (address out, data in)
//   out_valid/out_ready           output stream handshake
//   out_data, out_last            stream word and end-of-burst marker
//   busy                          command accepted and not yet finished
//   done                          one-cycle pulse on the final pop (or abort)
//   abort (ABORT_EN only)         cancel the active burst
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int addr_bits = 10,
  parameter int data_bits = 32,
  parameter int len_bits  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [addr_bits-1:0] cmd_addr,
  input  logic [len_bits-1:0]  cmd_len,
  output logic [addr_bits-1:0] ram_addr,
  input  logic [data_bits-1:0] ram_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [data_bits-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
`ifdef RAM_STREAM_READER_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t               state;
  logic [addr_bits-1:0] next_addr;
  logic [len_bits-1:0]  rem_cnt;
  // In-flight shift register: bit 0 set the edge the address is registered,
  // bit 1 the edge the RAM registers the data; the FIFO push follows.
  logic [1:0]           infl_vld;
  logic [1:0]           infl_last;

  logic [CW-1:0]        fifo_cnt;
  logic                 fifo_empty;
  logic [data_bits:0]   fifo_head;
  logic                 pop, push;
  logic                 issue, issue_ok;
  logic                 last_pop;
  logic                 abort_hit;
  logic [3:0]           occ;

`ifdef RAM_STREAM_READER_ABORT_EN
  assign abort_hit = abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[data_bits-1:0];
  assign out_last  = fifo_head[data_bits];
  assign pop       = out_valid && out_ready;
  assign push      = infl_vld[1];

  // Every issued word already owns a FIFO slot: buffered + in flight, minus
  // what leaves this cycle, must stay below the depth so nothing is dropped.
  assign occ      = 4'(fifo_cnt) + 4'(infl_vld[0]) + 4'(infl_vld[1]);
  assign issue_ok = (occ - 4'(pop)) < 4'(FIFO_DEPTH);
  assign issue    = (state == ST_ISSUE) && issue_ok && !abort_hit;

  assign last_pop = (state == ST_DRAIN) && pop && out_last;
  assign done     = last_pop || abort_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      next_addr <= '0;
      rem_cnt   <= '0;
      ram_addr  <= '0;
      infl_vld  <= '0;
      infl_last <= '0;
    end else if (abort_hit) begin
      // Drop the in-flight words so their RAM data is ignored on arrival.
      state     <= ST_IDLE;
      infl_vld  <= '0;
      infl_last <= '0;
    end else begin
      infl_vld  <= {infl_vld[0], issue};
      infl_last <= {infl_last[0], issue && (rem_cnt == '0)};
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            next_addr <= cmd_addr;
            rem_cnt   <= cmd_len;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            ram_addr  <= next_addr;
            next_addr <= next_addr + 1'b1;
            if (rem_cnt == '0) state <= ST_DRAIN;
            else               rem_cnt <= rem_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_pop) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (data_bits + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort_hit),
    .push  (push),
    .wdata ({infl_last[1], ram_dout}),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
//   Directed bench for ram_stream_reader with a behavioural registered-read
//   RAM and a scoreboard of expected {last,data} words.
//   Build with +define+RAM_STREAM_READER_ABORT_EN to cover the abort path.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_addr;
  logic [9:0]  cmd_len;
  logic [9:0]  ram_addr;
  logic [31:0] ram_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef RAM_STREAM_READER_ABORT_EN
  logic        abort;
`endif

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;

  logic [31:0] mem [1024];
  logic [32:0] exp_q [$];
  logic        stall_q = 1'b0;
  logic [31:0] stall_data = '0;

  always #5 clk = ~clk;

  ram_stream_reader #(.addr_bits(10), .data_bits(32), .len_bits(10)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef RAM_STREAM_READER_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // Registered-read RAM, no reset on the data path
  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: compares every accepted word against the queue
  always @(negedge clk) begin
    if (rst_n) begin
      chk("fifo_cnt_le4", 64'(u_dut.u_fifo.count <= 3'd4), 64'd1);
      if (stall_q) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(stall_data));
      end
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("word_data", 64'(out_data), 64'(e[31:0]));
          chk("word_last", 64'(out_last), 64'(e[32]));
        end
        pop_cnt++;
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic send_cmd(input logic [9:0] a, input logic [9:0] l);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    for (int i = 0; i <= int'(l); i++) begin
      logic [9:0] ad;
      ad = a + 10'(i);
      exp_q.push_back({(i == int'(l)), mem[ad]});
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pop_cnt < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pop_wait_timeout", 64'(pop_cnt >= target), 64'd1);
  endtask

  initial begin
    int d0;
    logic [3:0] pat;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    mem[5] = 32'hDEAD_BEEF;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
`ifdef RAM_STREAM_READER_ABORT_EN
    abort = 1'b0;
`endif

    // Reset values
    repeat (2) @(posedge clk); #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word: valid exactly 3 edges after the accept edge
    send_cmd(10'd5, 10'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_valid_e0", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_valid_e2", 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_valid_e3", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'hDEAD_BEEF);
    chk("t1_last", 64'(out_last), 64'd1);
    chk("t1_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    chk("t1_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_valid_end", 64'(out_valid), 64'd0);

    // Streaming: 8 words on 8 consecutive cycles, accepted back-to-back
    send_cmd(10'h010, 10'd7);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_last", 64'(out_last), 64'(k == 7));
      chk("t2_busy", 64'(busy), 64'd1);
      chk("t2_done", 64'(done), 64'(k == 7));
    end
    @(posedge clk); #1;
    chk("t2_drained", 64'(exp_q.size()), 64'd0);
    chk("t2_idle", 64'(cmd_ready), 64'd1);

    // Backpressure with a 1-0-0-1 ready pattern
    d0  = done_cnt;
    pat = 4'b1001;
    send_cmd(10'h040, 10'd15);
    begin
      int c = 0;
      while (exp_q.size() != 0 && c < 300) begin
        out_ready = pat[c % 4];
        @(posedge clk); #1;
        c++;
      end
    end
    out_ready = 1'b1;
    chk("t3_drained", 64'(exp_q.size()), 64'd0);
    chk("t3_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t3_busy_end", 64'(busy), 64'd0);

    // Address wrap from the top of the RAM
    d0 = done_cnt;
    send_cmd(10'h3FE, 10'd3);
    wait_drain("t4_drain", 50);
    chk("t4_done_once", 64'(done_cnt - d0), 64'd1);

    // Reset mid-burst after the third word
    d0 = pop_cnt;
    send_cmd(10'h080, 10'd15);
    wait_pops(d0 + 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_out_last", 64'(out_last), 64'd0);
    chk("t5_ram_addr", 64'(ram_addr), 64'd0);
    chk("t5_out_data", 64'(out_data), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    d0 = done_cnt;
    send_cmd(10'h200, 10'd5);
    wait_drain("t5_drain", 50);
    chk("t5_done_once", 64'(done_cnt - d0), 64'd1);

`ifdef RAM_STREAM_READER_ABORT_EN
    // Abort at the fourth word, then a clean follow-up burst
    d0 = pop_cnt;
    send_cmd(10'h0C0, 10'd15);
    wait_pops(d0 + 3);
    abort = 1'b1;
    @(negedge clk);
    chk("t6_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_valid_low", 64'(out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done_end", 64'(done), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    d0 = done_cnt;
    send_cmd(10'h300, 10'd4);
    wait_drain("t6_drain", 50);
    chk("t6_done_once", 64'(done_cnt - d0), 64'd1);
`endif

    repeat (3) @(posedge clk); #1;
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
